// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong ball logic: default playfield geometry,
// ball size, the ball controller state encoding and the frame timer width.
// No ports (package).
// -----------------------------------------------------------------------------
package pong_pkg;

    localparam int PONG_SCREEN_W  = 640;
    localparam int PONG_SCREEN_H  = 480;
    localparam int PONG_BALL_SIZE = 64;

    // Wide enough for any realistic cooldown / score-hold frame count.
    localparam int TIMER_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_HIT_HOLD,
        ST_SCORED
    } ball_state_t;

endpackage

// File: rtl/frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Loadable down-counter of video frames, shared by the paddle cooldown and
// the post-score freeze.
//
// Ports:
//   clk      - pixel clock
//   rst_n    - asynchronous active-low reset (count cleared)
//   load     - load load_val into the counter (wins over tick)
//   load_val - number of frame ticks in the interval
//   tick     - decrement by one (frame_tick while the interval runs)
//   done     - the tick arriving now is the last one of the interval
// -----------------------------------------------------------------------------
module frame_timer
    import pong_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] count;

    // done looks one tick ahead so the owner can leave its state on exactly
    // the Nth tick after loading N; a zero load also finishes on its first tick.
    assign done = (count <= W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/ball_motion.sv
// -----------------------------------------------------------------------------
// ball_motion
// Moves the pong ball once per video frame: serve from the centre, bounce off
// the top/bottom walls, reverse on paddle hits (with a cooldown that ignores
// further collisions), and report a score when the ball leaves either side.
//
// Ports:
//   pixel_clk     - the only clock
//   rst_n         - asynchronous active-low reset
//   frame_tick    - one-cycle pulse per video frame; all motion happens on it
//   serve         - launch request, sampled on a tick while IDLE
//   serve_dir     - launch direction, 0 = left, 1 = right
//   collide_left  - ball overlaps the left paddle
//   collide_right - ball overlaps the right paddle
//   ball_x/ball_y - top-left corner of the ball box (registered)
//   score_left    - one-cycle pulse, left player scored (registered)
//   score_right   - one-cycle pulse, right player scored (registered)
//   busy          - high in every state except IDLE (registered)
// -----------------------------------------------------------------------------
module ball_motion
    import pong_pkg::*;
#(
    parameter int SCREEN_W   = PONG_SCREEN_W,
    parameter int SCREEN_H   = PONG_SCREEN_H,
    parameter int BALL_SIZE  = PONG_BALL_SIZE,
    parameter int STEP       = 2,
    parameter int COOLDOWN   = 4,
    parameter int SCORE_HOLD = 60
) (
    input  logic       pixel_clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic       serve_dir,
    input  logic       collide_left,
    input  logic       collide_right,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       score_left,
    output logic       score_right,
    output logic       busy
);

    localparam logic [9:0]  CENTER_X = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]  CENTER_Y = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [9:0]  STEP_P   = 10'(STEP);
    // 11-bit copies so "position + size + step" can never overflow the compare.
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [10:0] SIZE_W   = 11'(BALL_SIZE);
    localparam logic [10:0] LIMIT_X  = 11'(SCREEN_W);
    localparam logic [10:0] LIMIT_Y  = 11'(SCREEN_H);
    localparam logic [TIMER_W-1:0] COOLDOWN_LOAD = TIMER_W'(COOLDOWN);
    localparam logic [TIMER_W-1:0] HOLD_LOAD     = TIMER_W'(SCORE_HOLD);

    ball_state_t state;
    logic        dx_right;
    logic        dy_down;

    logic        moving;
    logic        exit_left;
    logic        exit_right;
    logic        bounce_top;
    logic        bounce_bottom;
    logic        hit_left;
    logic        hit_right;
    logic        hit;
    logic        timer_load;
    logic        timer_tick;
    logic        timer_done;
    logic [TIMER_W-1:0] timer_val;

    assign moving = (state == ST_MOVE) || (state == ST_HIT_HOLD);

    // Bounds are tested against the current position before stepping, so the
    // unsigned coordinates never wrap.
    assign exit_left     = !dx_right && (ball_x < STEP_P);
    assign exit_right    =  dx_right && (({1'b0, ball_x} + SIZE_W + STEP_W) > LIMIT_X);
    assign bounce_top    = !dy_down  && (ball_y < STEP_P);
    assign bounce_bottom =  dy_down  && (({1'b0, ball_y} + SIZE_W + STEP_W) > LIMIT_Y);

    // Only a paddle the ball is heading towards counts, and never during the
    // cooldown; a valid hit pre-empts any score on the same tick.
    assign hit_left  = (state == ST_MOVE) && !dx_right && collide_left;
    assign hit_right = (state == ST_MOVE) &&  dx_right && collide_right;
    assign hit       = hit_left || hit_right;

    assign timer_load = frame_tick && moving && (hit || exit_left || exit_right);
    assign timer_val  = hit ? COOLDOWN_LOAD : HOLD_LOAD;
    assign timer_tick = frame_tick && ((state == ST_HIT_HOLD) || (state == ST_SCORED));

    frame_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk      (pixel_clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .tick     (timer_tick),
        .done     (timer_done)
    );

    // Ball controller: state, position, direction and all outputs are
    // registered here and only change on a frame tick (score pulses clear on
    // the following cycle).
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ball_x      <= CENTER_X;
            ball_y      <= CENTER_Y;
            dx_right    <= 1'b1;
            dy_down     <= 1'b1;
            score_left  <= 1'b0;
            score_right <= 1'b0;
            busy        <= 1'b0;
        end else begin
            score_left  <= 1'b0;
            score_right <= 1'b0;
            if (frame_tick) begin
                case (state)
                    ST_IDLE: begin
                        ball_x <= CENTER_X;
                        ball_y <= CENTER_Y;
                        if (serve) begin
                            dx_right <= serve_dir;
                            dy_down  <= 1'b1;
                            state    <= ST_MOVE;
                            busy     <= 1'b1;
                        end
                    end
                    ST_MOVE, ST_HIT_HOLD: begin
                        // Vertical motion is independent of what happens in x.
                        if (bounce_top || bounce_bottom) begin
                            dy_down <= !dy_down;
                        end else if (dy_down) begin
                            ball_y <= ball_y + STEP_P;
                        end else begin
                            ball_y <= ball_y - STEP_P;
                        end

                        if (hit) begin
                            dx_right <= hit_left;
                            ball_x   <= hit_left ? ball_x + STEP_P : ball_x - STEP_P;
                            state    <= ST_HIT_HOLD;
                        end else if (exit_left) begin
                            score_right <= 1'b1;
                            state       <= ST_SCORED;
                        end else if (exit_right) begin
                            score_left <= 1'b1;
                            state      <= ST_SCORED;
                        end else begin
                            ball_x <= dx_right ? ball_x + STEP_P : ball_x - STEP_P;
                            if ((state == ST_HIT_HOLD) && timer_done) begin
                                state <= ST_MOVE;
                            end
                        end
                    end
                    ST_SCORED: begin
                        if (timer_done) begin
                            state  <= ST_IDLE;
                            busy   <= 1'b0;
                            ball_x <= CENTER_X;
                            ball_y <= CENTER_Y;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// -----------------------------------------------------------------------------
// tb_ball_motion
// Self-checking bench for ball_motion at default parameters. A behavioural
// model predicts the outputs after each frame tick and queues them; each test
// task pops and compares once the DUT has produced that tick's result.
// -----------------------------------------------------------------------------
module tb_ball_motion;

    localparam int W    = 640;
    localparam int H    = 480;
    localparam int BS   = 64;
    localparam int STEP = 2;
    localparam int COOL = 4;
    localparam int HOLD = 60;
    localparam int CX   = (W - BS) / 2;
    localparam int CY   = (H - BS) / 2;

    localparam int M_IDLE   = 0;
    localparam int M_MOVE   = 1;
    localparam int M_HIT    = 2;
    localparam int M_SCORED = 3;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       sl;
        logic       sr;
        logic       busy;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       serve;
    logic       serve_dir;
    logic       collide_left;
    logic       collide_right;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       score_left;
    logic       score_right;
    logic       busy;

    obs_t exp_q[$];
    int   compared;
    int   mismatched;

    // Reference model state: signed positions and unit velocities.
    int mx, my, vdx, vdy, mst, mtimer;

    ball_motion dut (
        .pixel_clk     (clk),
        .rst_n         (rst_n),
        .frame_tick    (frame_tick),
        .serve         (serve),
        .serve_dir     (serve_dir),
        .collide_left  (collide_left),
        .collide_right (collide_right),
        .ball_x        (ball_x),
        .ball_y        (ball_y),
        .score_left    (score_left),
        .score_right   (score_right),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic obs_t observe();
        obs_t o;
        o.x    = ball_x;
        o.y    = ball_y;
        o.sl   = score_left;
        o.sr   = score_right;
        o.busy = busy;
        return o;
    endfunction

    function automatic obs_t make_obs(input logic sl, input logic sr);
        obs_t o;
        o.x    = 10'(mx);
        o.y    = 10'(my);
        o.sl   = sl;
        o.sr   = sr;
        o.busy = (mst != M_IDLE);
        return o;
    endfunction

    task automatic model_reset();
        mx = CX; my = CY; vdx = 1; vdy = 1; mst = M_IDLE; mtimer = 0;
    endtask

    task automatic model_tick(input logic s, input logic d, input logic cl, input logic cr);
        logic sl, sr;
        bit   hit;
        int   nx, ny;
        sl = 1'b0;
        sr = 1'b0;
        case (mst)
            M_IDLE: begin
                mx = CX; my = CY;
                if (s) begin
                    vdx = d ? 1 : -1;
                    vdy = 1;
                    mst = M_MOVE;
                end
            end
            M_MOVE, M_HIT: begin
                hit = (mst == M_MOVE) && ((vdx < 0 && cl) || (vdx > 0 && cr));
                ny = my + STEP * vdy;
                if (ny < 0 || ny + BS > H) vdy = -vdy;
                else my = ny;
                if (hit) begin
                    vdx = -vdx;
                    mx = mx + STEP * vdx;
                    mst = M_HIT;
                    mtimer = COOL;
                end else begin
                    nx = mx + STEP * vdx;
                    if (nx < 0) begin
                        sr = 1'b1; mst = M_SCORED; mtimer = HOLD;
                    end else if (nx + BS > W) begin
                        sl = 1'b1; mst = M_SCORED; mtimer = HOLD;
                    end else begin
                        mx = nx;
                        if (mst == M_HIT) begin
                            mtimer--;
                            if (mtimer == 0) mst = M_MOVE;
                        end
                    end
                end
            end
            default: begin
                mtimer--;
                if (mtimer == 0) begin
                    mx = CX; my = CY; mst = M_IDLE;
                end
            end
        endcase
        exp_q.push_back(make_obs(sl, sr));
    endtask

    // One quiet cycle (inputs already showing, no tick) followed by a tick
    // cycle; returns 1 ns after the sampling edge.
    task automatic drive_tick(input logic s, input logic d, input logic cl, input logic cr);
        @(negedge clk);
        frame_tick = 1'b0; serve = s; serve_dir = d; collide_left = cl; collide_right = cr;
        @(negedge clk);
        frame_tick = 1'b1;
        model_tick(s, d, cl, cr);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        frame_tick = 1'b0; serve = 1'b0; serve_dir = 1'b0;
        collide_left = 1'b0; collide_right = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got, expv;
        rst_n = 1'b1;
        frame_tick = 1'b0; serve = 1'b0; serve_dir = 1'b0;
        collide_left = 1'b0; collide_right = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        exp_q.push_back(make_obs(1'b0, 1'b0));
        #1;
        got = observe(); expv = exp_q.pop_front(); compared++;
        if (got !== expv) begin
            mismatched++;
            $display("[TB] FAIL reset: got x=%0d y=%0d sl=%b sr=%b busy=%b, expected x=%0d y=%0d sl=%b sr=%b busy=%b",
                     got.x, got.y, got.sl, got.sr, got.busy, expv.x, expv.y, expv.sl, expv.sr, expv.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_tick(1'b0, 1'b1, 1'b1, 1'b1);
            got = observe(); expv = exp_q.pop_front(); compared++;
            if (got !== expv) begin
                mismatched++;
                $display("[TB] FAIL idle_no_serve %0d: got x=%0d y=%0d sl=%b sr=%b busy=%b, expected x=%0d y=%0d sl=%b sr=%b busy=%b",
                         i, got.x, got.y, got.sl, got.sr, got.busy, expv.x, expv.y, expv.sl, expv.sr, expv.busy);
            end
        end
    endtask

    task automatic test_serve_right_score();
        obs_t got, expv;
        apply_reset();
        for (int t = 0; t <= 145; t++) begin
            drive_tick(t == 0, 1'b1, 1'b0, 1'b0);
            got = observe(); expv = exp_q.pop_front(); compared++;
            if (got !== expv) begin
                mismatched++;
                $display("[TB] FAIL serve_right tick %0d: got x=%0d y=%0d sl=%b sr=%b busy=%b, expected x=%0d y=%0d sl=%b sr=%b busy=%b",
                         t, got.x, got.y, got.sl, got.sr, got.busy, expv.x, expv.y, expv.sl, expv.sr, expv.busy);
            end
            if (t == 104 || t == 105 || t == 106) begin
                compared++;
                if (ball_y !== ((t == 106) ? 10'd414 : 10'd416)) begin
                    mismatched++;
                    $display("[TB] FAIL bottom_bounce tick %0d: got y=%0d, expected y=%0d",
                             t, ball_y, (t == 106) ? 414 : 416);
                end
            end
            if (t == 144) begin
                compared++;
                if (ball_x !== 10'd576 || score_left !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL right_edge_x: got x=%0d sl=%b, expected x=576 sl=0", ball_x, score_left);
                end
            end
            if (t == 145) begin
                compared++;
                if (score_left !== 1'b1 || score_right !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL score_left_pulse: got sl=%b sr=%b, expected sl=1 sr=0", score_left, score_right);
                end
            end
        end
        @(posedge clk);
        #1;
        compared++;
        if (score_left !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL score_pulse_width: got sl=%b busy=%b, expected sl=0 busy=1", score_left, busy);
        end
    endtask

    task automatic test_scored_hold();
        obs_t got, expv;
        for (int t = 1; t <= HOLD; t++) begin
            drive_tick(1'b1, 1'b0, 1'b0, 1'b0);
            got = observe(); expv = exp_q.pop_front(); compared++;
            if (got !== expv) begin
                mismatched++;
                $display("[TB] FAIL scored_hold tick %0d: got x=%0d y=%0d sl=%b sr=%b busy=%b, expected x=%0d y=%0d sl=%b sr=%b busy=%b",
                         t, got.x, got.y, got.sl, got.sr, got.busy, expv.x, expv.y, expv.sl, expv.sr, expv.busy);
            end
        end
        compared++;
        if (ball_x !== 10'd288 || ball_y !== 10'd208 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL scored_recentre: got x=%0d y=%0d busy=%b, expected x=288 y=208 busy=0", ball_x, ball_y, busy);
        end
    endtask

    task automatic test_paddle_hit();
        obs_t got, expv;
        apply_reset();
        // Serve left; a right-paddle collide is ignored while heading left.
        for (int t = 0; t <= 10; t++) begin
            drive_tick(t == 0, 1'b0, 1'b0, t > 5);
            got = observe(); expv = exp_q.pop_front(); compared++;
            if (got !== expv) begin
                mismatched++;
                $display("[TB] FAIL approach_left tick %0d: got x=%0d y=%0d sl=%b sr=%b busy=%b, expected x=%0d y=%0d sl=%b sr=%b busy=%b",
                         t, got.x, got.y, got.sl, got.sr, got.busy, expv.x, expv.y, expv.sl, expv.sr, expv.busy);
            end
        end
        for (int t = 0; t < 6; t++) begin
            drive_tick(1'b0, 1'b0, 1'b1, 1'b0);
            got = observe(); expv = exp_q.pop_front(); compared++;
            if (got !== expv) begin
                mismatched++;
                $display("[TB] FAIL hold_collide tick %0d: got x=%0d y=%0d sl=%b sr=%b busy=%b, expected x=%0d y=%0d sl=%b sr=%b busy=%b",
                         t, got.x, got.y, got.sl, got.sr, got.busy, expv.x, expv.y, expv.sl, expv.sr, expv.busy);
            end
        end
        compared++;
        if (ball_x !== 10'd280) begin
            mismatched++;
            $display("[TB] FAIL single_reversal: got x=%0d, expected x=280", ball_x);
        end
        // Back in MOVE heading right, so the right paddle is live again.
        drive_tick(1'b0, 1'b0, 1'b0, 1'b1);
        got = observe(); expv = exp_q.pop_front(); compared++;
        if (got !== expv) begin
            mismatched++;
            $display("[TB] FAIL right_hit: got x=%0d y=%0d sl=%b sr=%b busy=%b, expected x=%0d y=%0d sl=%b sr=%b busy=%b",
                     got.x, got.y, got.sl, got.sr, got.busy, expv.x, expv.y, expv.sl, expv.sr, expv.busy);
        end
        compared++;
        if (ball_x !== 10'd278) begin
            mismatched++;
            $display("[TB] FAIL move_after_cooldown: got x=%0d, expected x=278", ball_x);
        end
    endtask

    task automatic test_edge_collide();
        obs_t got, expv;
        apply_reset();
        for (int t = 0; t <= 145; t++) begin
            drive_tick(t == 0, 1'b0, t == 145, 1'b0);
            got = observe(); expv = exp_q.pop_front(); compared++;
            if (got !== expv) begin
                mismatched++;
                $display("[TB] FAIL edge_collide tick %0d: got x=%0d y=%0d sl=%b sr=%b busy=%b, expected x=%0d y=%0d sl=%b sr=%b busy=%b",
                         t, got.x, got.y, got.sl, got.sr, got.busy, expv.x, expv.y, expv.sl, expv.sr, expv.busy);
            end
            if (t == 144) begin
                compared++;
                if (ball_x !== 10'd0) begin
                    mismatched++;
                    $display("[TB] FAIL left_edge_x: got x=%0d, expected x=0", ball_x);
                end
            end
        end
        compared++;
        if (ball_x !== 10'd2 || score_right !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL collide_beats_score: got x=%0d sr=%b busy=%b, expected x=2 sr=0 busy=1", ball_x, score_right, busy);
        end
    endtask

    task automatic test_score_right();
        obs_t got, expv;
        apply_reset();
        for (int t = 0; t <= 145; t++) begin
            drive_tick(t == 0, 1'b0, 1'b0, 1'b0);
            got = observe(); expv = exp_q.pop_front(); compared++;
            if (got !== expv) begin
                mismatched++;
                $display("[TB] FAIL score_right tick %0d: got x=%0d y=%0d sl=%b sr=%b busy=%b, expected x=%0d y=%0d sl=%b sr=%b busy=%b",
                         t, got.x, got.y, got.sl, got.sr, got.busy, expv.x, expv.y, expv.sl, expv.sr, expv.busy);
            end
        end
        compared++;
        if (score_right !== 1'b1 || score_left !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL score_right_pulse: got sr=%b sl=%b, expected sr=1 sl=0", score_right, score_left);
        end
    endtask

    task automatic test_async_reset();
        obs_t got, expv;
        apply_reset();
        for (int t = 0; t <= 20; t++) begin
            drive_tick(t == 0, 1'b1, 1'b0, 1'b0);
            got = observe(); expv = exp_q.pop_front(); compared++;
            if (got !== expv) begin
                mismatched++;
                $display("[TB] FAIL pre_abort tick %0d: got x=%0d y=%0d sl=%b sr=%b busy=%b, expected x=%0d y=%0d sl=%b sr=%b busy=%b",
                         t, got.x, got.y, got.sl, got.sr, got.busy, expv.x, expv.y, expv.sl, expv.sr, expv.busy);
            end
        end
        // Assert reset between clock edges and look before any edge arrives.
        #2;
        rst_n = 1'b0;
        model_reset();
        exp_q.push_back(make_obs(1'b0, 1'b0));
        #1;
        got = observe(); expv = exp_q.pop_front(); compared++;
        if (got !== expv) begin
            mismatched++;
            $display("[TB] FAIL async_abort: got x=%0d y=%0d sl=%b sr=%b busy=%b, expected x=%0d y=%0d sl=%b sr=%b busy=%b",
                     got.x, got.y, got.sl, got.sr, got.busy, expv.x, expv.y, expv.sl, expv.sr, expv.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            drive_tick(t == 5, 1'b0, 1'b1, 1'b0);
            got = observe(); expv = exp_q.pop_front(); compared++;
            if (got !== expv) begin
                mismatched++;
                $display("[TB] FAIL post_abort tick %0d: got x=%0d y=%0d sl=%b sr=%b busy=%b, expected x=%0d y=%0d sl=%b sr=%b busy=%b",
                         t, got.x, got.y, got.sl, got.sr, got.busy, expv.x, expv.y, expv.sl, expv.sr, expv.busy);
            end
        end
        drive_tick(1'b0, 1'b0, 1'b0, 1'b0);
        got = observe(); expv = exp_q.pop_front(); compared++;
        if (got !== expv) begin
            mismatched++;
            $display("[TB] FAIL restart_move: got x=%0d y=%0d sl=%b sr=%b busy=%b, expected x=%0d y=%0d sl=%b sr=%b busy=%b",
                     got.x, got.y, got.sl, got.sr, got.busy, expv.x, expv.y, expv.sl, expv.sr, expv.busy);
        end
        compared++;
        if (ball_x !== 10'd286 || busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL restart_left: got x=%0d busy=%b, expected x=286 busy=1", ball_x, busy);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_serve_right_score();
        test_scored_hold();
        test_paddle_hit();
        test_edge_collide();
        test_score_right();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
